// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/debug controller for the 16-bit single-cycle core
// Stretched core reset, run/step/resume gating, cycle count, halt on HALT/breakpoint/timeout.
module cpu_run_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int NUM_BP     = 2,
  parameter int RST_CYCLES = 4,
  parameter int CYC_W      = 32,
  localparam int BP_IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     run_i,
  input  logic                     step_i,
  input  logic                     resume_i,
  input  logic [NUM_BP-1:0]        bp_en_i,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
  input  logic [CYC_W-1:0]         timeout_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic                     halt_instr_i,
  output logic                     core_rst_n_o,
  output logic                     core_en_o,
  output logic [2:0]               state_o,
  output logic [CYC_W-1:0]         cycles_o,
  output logic [2:0]               halt_cause_o,
  output logic [BP_IDX_W-1:0]      bp_idx_o,
  output logic                     done_o
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_HALT = 3'd1;
  localparam logic [2:0] C_BP   = 3'd2;
  localparam logic [2:0] C_TMO  = 3'd3;
  localparam logic [2:0] C_STEP = 3'd4;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state;
  logic [1:0]          sync;
  logic [RC_W-1:0]     rst_cnt;
  logic                core_rst_n;
  logic [CYC_W-1:0]    cycles;
  logic [2:0]          cause;
  logic [BP_IDX_W-1:0] bp_idx;
  logic                suppress;

  logic                bp_any;
  logic [BP_IDX_W-1:0] hit_idx;
  logic                bp_hit;
  logic [CYC_W-1:0]    cyc_inc;
  logic [CYC_W:0]      cyc_next_wide;
  logic                timeout_hit;

  // Scan downwards so the lowest matching comparator index is the one kept.
  always_comb begin
    bp_any  = 1'b0;
    hit_idx = '0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (bp_en_i[k] && (pc_i == bp_addr_i[k*ADDR_W +: ADDR_W])) begin
        bp_any  = 1'b1;
        hit_idx = BP_IDX_W'(k);
      end
    end
  end

  assign bp_hit        = (state == S_RUN) && bp_any && !suppress;
  assign core_en_o     = (state == S_STEP) || ((state == S_RUN) && !bp_hit);
  assign cyc_inc       = (&cycles) ? cycles : cycles + 1'b1;
  assign cyc_next_wide = {1'b0, cycles} + 1'b1;
  assign timeout_hit   = (timeout_i != '0) && (cyc_next_wide >= {1'b0, timeout_i});

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync       <= 2'b00;
      state      <= S_RESET;
      rst_cnt    <= '0;
      core_rst_n <= 1'b0;
      cycles     <= '0;
      cause      <= C_NONE;
      bp_idx     <= '0;
      suppress   <= 1'b0;
    end else begin
      sync <= {sync[0], 1'b1};
      case (state)
        S_RESET: begin
          // Hold off counting until the released reset has crossed the synchroniser.
          if (sync[1]) begin
            if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
              state      <= S_IDLE;
              core_rst_n <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (step_i)     state <= S_STEP;
          else if (run_i) state <= S_RUN;
        end
        S_RUN: begin
          suppress <= 1'b0;
          if (core_en_o) cycles <= cyc_inc;
          if (halt_instr_i && core_en_o) begin
            state <= S_HALT;
            cause <= C_HALT;
          end else if (bp_hit) begin
            state  <= S_HALT;
            cause  <= C_BP;
            bp_idx <= hit_idx;
          end else if (core_en_o && timeout_hit) begin
            state <= S_HALT;
            cause <= C_TMO;
          end
        end
        S_STEP: begin
          cycles <= cyc_inc;
          state  <= S_HALT;
          cause  <= halt_instr_i ? C_HALT : C_STEP;
        end
        S_HALT: begin
          if (run_i) begin
            state      <= S_RESET;
            rst_cnt    <= '0;
            core_rst_n <= 1'b0;
            cycles     <= '0;
            cause      <= C_NONE;
          end else if (step_i) begin
            state <= S_STEP;
            cause <= C_NONE;
          end else if (resume_i) begin
            state    <= S_RUN;
            cause    <= C_NONE;
            suppress <= 1'b1;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

  assign core_rst_n_o = core_rst_n;
  assign state_o      = state;
  assign cycles_o     = cycles;
  assign halt_cause_o = cause;
  assign bp_idx_o     = bp_idx;
  assign done_o       = (state == S_HALT);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - randomized self-checking bench for cpu_run_ctrl
// A mode-level reference model predicts every output each cycle.
module tb_cpu_run_ctrl;

  localparam int ADDR_W     = 16;
  localparam int NUM_BP     = 2;
  localparam int RST_CYCLES = 4;
  localparam int CYC_W      = 32;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic                     run_i = 1'b0;
  logic                     step_i = 1'b0;
  logic                     resume_i = 1'b0;
  logic [NUM_BP-1:0]        bp_en_i = '0;
  logic [NUM_BP*ADDR_W-1:0] bp_addr_i = '0;
  logic [CYC_W-1:0]         timeout_i = '0;
  logic [ADDR_W-1:0]        pc_i = '0;
  logic                     halt_instr_i = 1'b0;
  logic                     core_rst_n_o;
  logic                     core_en_o;
  logic [2:0]               state_o;
  logic [CYC_W-1:0]         cycles_o;
  logic [2:0]               halt_cause_o;
  logic                     bp_idx_o;
  logic                     done_o;

  cpu_run_ctrl #(
    .ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .RST_CYCLES(RST_CYCLES), .CYC_W(CYC_W)
  ) dut (
    .CLK(CLK), .RST(RST), .run_i(run_i), .step_i(step_i), .resume_i(resume_i),
    .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .timeout_i(timeout_i), .pc_i(pc_i),
    .halt_instr_i(halt_instr_i), .core_rst_n_o(core_rst_n_o), .core_en_o(core_en_o),
    .state_o(state_o), .cycles_o(cycles_o), .halt_cause_o(halt_cause_o),
    .bp_idx_o(bp_idx_o), .done_o(done_o)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: modes 0=reset 1=idle 2=run 3=step 4=halt
  int               m_mode;
  int               m_wait;
  logic [CYC_W-1:0] m_cyc;
  int               m_cause;
  int               m_bpidx;
  bit               m_rstn;
  bit               m_sup;
  bit               m_en;
  bit               m_hit;
  int               m_hitidx;
  bit               obs_en;

  function automatic void model_reset();
    m_mode  = 0;
    m_wait  = 2 + RST_CYCLES;
    m_cyc   = '0;
    m_cause = 0;
    m_bpidx = 0;
    m_rstn  = 0;
    m_sup   = 0;
  endfunction

  function automatic void model_comb();
    m_hit    = 0;
    m_hitidx = 0;
    if (m_mode == 2 && !m_sup) begin
      for (int k = 0; k < NUM_BP; k++) begin
        if (bp_en_i[k] && pc_i == bp_addr_i[k*ADDR_W +: ADDR_W]) begin
          m_hit    = 1;
          m_hitidx = k;
          break;
        end
      end
    end
    m_en = (m_mode == 3) || (m_mode == 2 && !m_hit);
  endfunction

  function automatic void model_edge();
    longint executed;
    case (m_mode)
      0: begin
        m_wait--;
        if (m_wait == 0) begin m_mode = 1; m_rstn = 1; end
      end
      1: begin
        if (step_i) m_mode = 3;
        else if (run_i) m_mode = 2;
      end
      2: begin
        m_sup = 0;
        executed = longint'(m_cyc) + (m_en ? 1 : 0);
        if (m_en && m_cyc != '1) m_cyc = m_cyc + 1;
        if (halt_instr_i && m_en) begin m_mode = 4; m_cause = 1; end
        else if (m_hit) begin m_mode = 4; m_cause = 2; m_bpidx = m_hitidx; end
        else if (m_en && timeout_i != 0 && executed >= longint'(timeout_i)) begin
          m_mode = 4; m_cause = 3;
        end
      end
      3: begin
        if (m_cyc != '1) m_cyc = m_cyc + 1;
        m_mode  = 4;
        m_cause = halt_instr_i ? 1 : 4;
      end
      4: begin
        if (run_i) begin
          m_mode = 0; m_wait = RST_CYCLES; m_cyc = '0; m_cause = 0; m_rstn = 0;
        end else if (step_i) begin
          m_mode = 3; m_cause = 0;
        end else if (resume_i) begin
          m_mode = 2; m_cause = 0; m_sup = 1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_regs();
    check("state", 64'(state_o), 64'(m_mode));
    check("cycles", 64'(cycles_o), 64'(m_cyc));
    check("cause", 64'(halt_cause_o), 64'(m_cause));
    check("bp_idx", 64'(bp_idx_o), 64'(m_bpidx));
    check("done", 64'(done_o), 64'(m_mode == 4));
    check("core_rst_n", 64'(core_rst_n_o), 64'(m_rstn));
  endtask

  // Inputs are changed by callers just after tick returns (posedge + 1).
  task automatic tick();
    @(negedge CLK);
    model_comb();
    obs_en = core_en_o;
    check("core_en", 64'(core_en_o), 64'(m_en));
    @(posedge CLK);
    if (RST) model_edge();
    #1;
    check_regs();
  endtask

  task automatic async_reset();
    RST = 1'b0;
    #1;
    model_reset();
    check("ar_core_rst_n", 64'(core_rst_n_o), 64'd0);
    check("ar_core_en", 64'(core_en_o), 64'd0);
    check("ar_state", 64'(state_o), 64'd0);
    check("ar_cycles", 64'(cycles_o), 64'd0);
    check("ar_done", 64'(done_o), 64'd0);
  endtask

  task automatic wait_mode(input int mode, input int limit, input string tag);
    int n = 0;
    while (state_o != 3'(mode) && n < limit) begin tick(); n++; end
    check(tag, 64'(state_o), 64'(mode));
  endtask

  task automatic pulse_run();    run_i = 1;    tick(); run_i = 0;    endtask
  task automatic pulse_step();   step_i = 1;   tick(); step_i = 0;   endtask
  task automatic pulse_resume(); resume_i = 1; tick(); resume_i = 0; endtask

  int n;
  int en_cnt;
  logic [CYC_W-1:0] c0;

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_regs();
    check("rst_core_en", 64'(core_en_o), 64'd0);

    // Reset stretch: synchroniser plus RST_CYCLES before core reset lifts.
    RST = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!core_rst_n_o && n < 20);
    check("t1_rst_len", 64'(n), 64'(2 + RST_CYCLES));
    check("t1_state", 64'(state_o), 64'd1);

    // Timeout run.
    timeout_i = 20;
    pulse_run();
    en_cnt = 0; n = 0;
    while (state_o != 3'd4 && n < 100) begin tick(); en_cnt += obs_en; n++; end
    check("t2_en_cnt", 64'(en_cnt), 64'd20);
    check("t2_cause", 64'(halt_cause_o), 64'd3);
    check("t2_cycles", 64'(cycles_o), 64'd20);
    check("t2_done", 64'(done_o), 64'd1);

    // Breakpoint on bp1, then resume through it.
    timeout_i = 0;
    bp_en_i   = 2'b10;
    bp_addr_i = {16'h0010, 16'h0100};
    pc_i      = 16'h0000;
    pulse_run();
    wait_mode(1, 20, "t3_idle");
    pulse_run();
    n = 0;
    while (state_o != 3'd4 && n < 50) begin
      tick();
      if (obs_en) pc_i = pc_i + 16'd2;
      n++;
    end
    check("t3_cause", 64'(halt_cause_o), 64'd2);
    check("t3_bp_idx", 64'(bp_idx_o), 64'd1);
    check("t3_pc", 64'(pc_i), 64'h10);
    pulse_resume();
    tick();
    check("t3_resume_en", 64'(obs_en), 64'd1);
    pc_i = pc_i + 16'd2;
    repeat (3) begin tick(); pc_i = pc_i + 16'd2; end
    check("t3_running", 64'(state_o), 64'd2);
    halt_instr_i = 1;
    tick();
    halt_instr_i = 0;
    check("t3_halt_cause", 64'(halt_cause_o), 64'd1);

    // Three single steps.
    c0 = m_cyc;
    for (int s = 0; s < 3; s++) begin
      en_cnt = 0;
      pulse_step(); en_cnt += obs_en;
      tick();       en_cnt += obs_en;
      tick();       en_cnt += obs_en;
      check("t4_step_en", 64'(en_cnt), 64'd1);
      check("t4_cause", 64'(halt_cause_o), 64'd4);
    end
    check("t4_cycles", 64'(cycles_o), 64'(c0 + 3));

    // HALT instruction wins over a breakpoint and a timeout in the same cycle.
    c0 = m_cyc;
    bp_en_i   = 2'b01;
    bp_addr_i = {16'h0010, pc_i};
    timeout_i = c0 + 1;
    pulse_resume();
    halt_instr_i = 1;
    tick();
    halt_instr_i = 0;
    check("t5_cause", 64'(halt_cause_o), 64'd1);
    check("t5_cycles", 64'(cycles_o), 64'(c0 + 1));

    // Asynchronous abort mid-run.
    bp_en_i = '0;
    timeout_i = 0;
    pulse_resume();
    repeat (3) tick();
    async_reset();
    repeat (2) tick();
    RST = 1'b1;
    wait_mode(1, 20, "t6_idle");

    // Randomized operation against the model.
    bp_addr_i = {16'($urandom_range(0, 40) * 2), 16'($urandom_range(0, 40) * 2)};
    for (int i = 0; i < 3000; i++) begin
      run_i        = ($urandom % 25) == 0;
      step_i       = ($urandom % 10) == 0;
      resume_i     = ($urandom % 6) == 0;
      halt_instr_i = ($urandom % 15) == 0;
      bp_en_i      = 2'($urandom);
      case ($urandom % 4)
        0: pc_i = bp_addr_i[15:0];
        1: pc_i = bp_addr_i[31:16];
        default: pc_i = 16'($urandom_range(0, 40) * 2);
      endcase
      if ($urandom % 30 == 0)
        timeout_i = ($urandom % 3 == 0) ? '0 : m_cyc + 32'($urandom_range(0, 25));
      if ($urandom % 400 == 0)
        bp_addr_i = {16'($urandom_range(0, 40) * 2), 16'($urandom_range(0, 40) * 2)};
      if ($urandom % 600 == 0) begin
        async_reset();
        tick();
        RST = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run/debug controller placed beside the 16-bit single-cycle core, replacing fixed-time bench sequencing.
- Generates a synchronised, stretched core reset.
- Gates core execution with a clock enable; supports run, single-step and resume.
- Counts executed cycles and halts on a HALT instruction, on a parametrised set of PC breakpoints, or on a programmable cycle timeout.
- Reports the halt cause.

Parameters:
ADDR_W, 16, PC/breakpoint address width
NUM_BP, 2, number of PC breakpoint comparators
RST_CYCLES, 4, core reset hold length in CLK cycles after synchronised reset release (>=1)
CYC_W, 32, cycle counter / timeout width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
run_i  in  1  start pulse: full core reset, then run
step_i  in  1  execute exactly one core cycle
resume_i  in  1  continue running from HALT
bp_en_i  in  NUM_BP  per-breakpoint enable
bp_addr_i  in  NUM_BP*ADDR_W  breakpoint addresses; bp k at bits [k*ADDR_W +: ADDR_W]
timeout_i  in  CYC_W  cycle limit; 0 = no timeout
pc_i  in  ADDR_W  current core PC
halt_instr_i  in  1  core decoded HALT in current cycle
core_rst_n_o  out  1  core reset, active-low
core_en_o  out  1  core clock enable (combinational)
state_o  out  3  0=RESET 1=IDLE 2=RUN 3=STEP 4=HALT
cycles_o  out  CYC_W  executed (enabled) cycle count
halt_cause_o  out  3  0=none 1=halt_instr 2=breakpoint 3=timeout 4=step
bp_idx_o  out  $clog2(NUM_BP) or 1  index of the breakpoint that fired (lowest index wins)
done_o  out  1  high while state==HALT

Behaviour:
Reset:
- RST low asynchronously forces RESET state, core_rst_n_o=0, core_en_o=0, cycles_o=0, halt_cause_o=0, bp_idx_o=0, done_o=0, reset counter=0.
- RST release passes through a 2-flop synchroniser. The reset counter starts only after that.

RESET:
- core_rst_n_o=0; the counter increments each cycle.
- When the counter reaches RST_CYCLES-1, go to IDLE. core_rst_n_o goes 1 on entering IDLE.

IDLE:
- core_en_o=0.
- step_i -> STEP; otherwise run_i -> RUN.

RUN:
- bp_hit = OR over k of (bp_en_i[k] && pc_i==bp addr k), masked when the suppress flag is set.
- core_en_o = !bp_hit. A breakpointed instruction does not execute.
- Each enabled cycle: cycles_o++, saturating at all-ones.
- Next-state priority, evaluated each cycle:
  1. halt_instr_i && core_en_o -> HALT, cause 1 (that cycle is counted).
  2. bp_hit -> HALT, cause 2, bp_idx_o latched.
  3. timeout_i!=0 && (cycles_o+1)>=timeout_i on an enabled cycle -> HALT, cause 3. cycles_o equals timeout_i on entry to HALT.
- The suppress flag clears after the first RUN cycle.

STEP:
- core_en_o=1 for exactly one cycle; breakpoints ignored; cycles_o++.
- Next state HALT: cause 1 if halt_instr_i, else cause 4.

HALT:
- core_en_o=0; done_o=1; halt_cause_o and bp_idx_o are held.
- Input priority: run_i > step_i > resume_i.
  - run_i -> RESET: clear cycles_o and cause, reassert core_rst_n_o.
  - step_i -> STEP.
  - resume_i -> RUN, set suppress flag so the instruction at a breakpoint PC executes.
- Resume after cause 1 is allowed; the core decides its own next PC.
- Cause is cleared to 0 on leaving HALT.

Other rules:
- run_i in RUN or STEP is ignored; resume_i outside HALT is ignored; step_i in RUN is ignored.
- RST asserted in any state aborts immediately to RESET with all reset values.
- Timeout uses the live timeout_i. Lowering it below cycles_o while in RUN halts on the next enabled cycle.

Test Plan:
1. RST low 2 cycles, then high, RST_CYCLES=4 -> core_rst_n_o stays 0 for 2 synchroniser cycles + 4 cycles, then 1; state_o=1; cycles_o=0.
2. run_i pulse, timeout_i=20, no bp, no halt -> exactly 20 core_en_o cycles; state_o=4, halt_cause_o=3, cycles_o=20, done_o=1.
3. bp_en_i=2'b10, bp1 addr=0x0010, pc_i ramps 0,2,4..., run -> core_en_o=0 when pc_i=0x0010; halt_cause_o=2, bp_idx_o=1. Then resume_i -> first cycle enabled at 0x0010, RUN continues.
4. In HALT, step_i pulse x3 -> core_en_o high exactly one cycle per pulse; cycles_o +3; halt_cause_o=4 each time.
5. halt_instr_i=1 while pc_i equals an enabled bp after resume, and timeout reached the same cycle -> cause 1 (halt_instr priority); cycles_o counts that cycle.
6. RST driven low mid-RUN asynchronously -> core_rst_n_o=0, core_en_o=0, state_o=0, cycles_o=0 without waiting for a CLK edge.
